// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: turns host commands into per-bit J/K drive vectors for
// a bank of WIDTH JK flip-flops. The bank state lives here and only ever
// changes through the JK characteristic equation at EXEC edges.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;
  localparam logic [2:0] OP_SHIFT  = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  state_t             state_r, state_nxt_s;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   data_r;
  logic [CNT_W-1:0]   rem_r;
  logic [WIDTH-1:0]   q_r;
  logic               wrapped_r, err_r, live_r;
  logic [WIDTH-1:0]   j_s, k_s, cnt_t_s;
  logic               carry_s;
  logic               multi_s, active_s, last_s, accept_s;

  // JK characteristic: Qn = J & ~Q | ~K & Q
  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] qv,
                                               input logic [WIDTH-1:0] jv,
                                               input logic [WIDTH-1:0] kv);
    return (jv & ~qv) | (~kv & qv);
  endfunction

  assign multi_s   = (op_r == OP_COUNT) || (op_r == OP_SHIFT);
  // A step really drives the bank unless aborted or a zero-length multi-step op
  assign active_s  = (state_r == EXEC) && !abort && !(multi_s && (rem_r == CNT_ZERO));
  assign last_s    = abort || !multi_s || (rem_r == CNT_ZERO) || (rem_r == CNT_ONE);
  assign cmd_ready = live_r && (state_r == IDLE);
  assign accept_s  = cmd_valid && cmd_ready;

  // Counter toggle enables: bit i toggles when all lower bits are one
  always_comb begin
    carry_s = 1'b1;
    cnt_t_s = ALL_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_t_s[i] = carry_s;
      carry_s    = carry_s & q_r[i];
    end
  end

  // J/K drive from the latched command and the current bank state
  always_comb begin
    j_s = ALL_ZERO;
    k_s = ALL_ZERO;
    if (active_s) begin
      case (op_r)
        OP_CLEAR:  begin j_s = ALL_ZERO; k_s = ALL_ONES; end
        OP_SET:    begin j_s = ALL_ONES; k_s = ALL_ZERO; end
        OP_LOAD:   begin j_s = data_r;   k_s = ~data_r;  end
        OP_TOGGLE: begin j_s = data_r;   k_s = data_r;   end
        OP_COUNT:  begin j_s = cnt_t_s;  k_s = cnt_t_s;  end
        OP_SHIFT: begin
          j_s = {q_r[WIDTH-2:0], data_r[0]};
          k_s = ~{q_r[WIDTH-2:0], data_r[0]};
        end
        OP_NOP, OP_ILL: begin j_s = ALL_ZERO; k_s = ALL_ZERO; end
        default:   begin j_s = ALL_ZERO; k_s = ALL_ZERO; end
      endcase
    end else begin
      j_s = ALL_ZERO;
      k_s = ALL_ZERO;
    end
  end

  // Next-state logic for the IDLE/EXEC/DONE controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = EXEC;
        else          state_nxt_s = IDLE;
      end
      EXEC: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = EXEC;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, command latch, bank update and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= OP_NOP;
      data_r    <= ALL_ZERO;
      rem_r     <= CNT_ZERO;
      q_r       <= ALL_ZERO;
      wrapped_r <= 1'b0;
      err_r     <= 1'b0;
      live_r    <= 1'b0;
    end else begin
      live_r  <= 1'b1;
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_r      <= cmd_op;
        data_r    <= cmd_data;
        rem_r     <= cmd_count;
        wrapped_r <= 1'b0;
        err_r     <= (cmd_op == OP_ILL);
      end else if (state_r == EXEC) begin
        q_r <= jk_next(q_r, j_s, k_s);
        if (rem_r != CNT_ZERO) rem_r <= rem_r - CNT_ONE;
        if (active_s && (op_r == OP_COUNT) && (q_r == ALL_ONES)) wrapped_r <= 1'b1;
      end
    end
  end

  assign j_out   = j_s;
  assign k_out   = k_s;
  assign q       = q_r;
  assign busy    = (state_r != IDLE);
  assign done    = (state_r == DONE);
  assign wrapped = wrapped_r;
  assign err     = err_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Testbench for jk_bank_sequencer: transaction-level model of the bank,
// directed scenarios with literal pins, then randomized commands.
module tb_jk_bank_sequencer;
  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic [W-1:0]  j_out, k_out, q;
  logic          busy, done, wrapped, err;

  jk_bank_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .abort(abort),
    .j_out(j_out), .k_out(k_out), .q(q), .busy(busy), .done(done),
    .wrapped(wrapped), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state and expected per-cycle outputs
  int m_q, m_wrapped, m_err;
  int exp_j, exp_k, exp_busy, exp_done, exp_ready;
  int first_j;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic idle_exp();
    exp_j = 0; exp_k = 0; exp_busy = 0; exp_done = 0; exp_ready = 1;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q",         32'(q),         32'(m_q));
      chk("j_out",     32'(j_out),     32'(exp_j));
      chk("k_out",     32'(k_out),     32'(exp_k));
      chk("busy",      32'(busy),      32'(exp_busy));
      chk("done",      32'(done),      32'(exp_done));
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("wrapped",   32'(wrapped),   32'(m_wrapped));
      chk("err",       32'(err),       32'(m_err));
    end
  end

  // Issue one command from an idle cycle; returns in the following idle cycle
  task automatic do_cmd(input int op, input int data, input int count, input int abort_at);
    int  n, jv, kv;
    bit  multi, act;
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = W'(data);
    cmd_count = CW'(count);
    abort     = 1'($urandom_range(0, 1));
    idle_exp();
    @(posedge clk); #1;
    // inputs after accept must not matter
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_data  = W'($urandom_range(0, MASK));
    cmd_count = CW'($urandom_range(0, 15));
    m_wrapped = 0;
    m_err     = (op == 7) ? 1 : 0;
    multi     = (op == 5) || (op == 6);
    n         = multi ? ((count == 0) ? 1 : count) : 1;
    for (int c = 1; c <= n; c++) begin
      act = (c != abort_at) && (op != 0) && (op != 7) && !(multi && count == 0);
      jv = 0; kv = 0;
      if (act) begin
        case (op)
          1: kv = MASK;
          2: jv = MASK;
          3: begin jv = data & MASK; kv = ~data & MASK; end
          4: begin jv = data & MASK; kv = data & MASK; end
          5: begin jv = (m_q ^ (m_q + 1)) & MASK; kv = jv; end
          6: begin jv = ((m_q << 1) | (data & 1)) & MASK; kv = ~jv & MASK; end
          default: ;
        endcase
      end
      if (c == 1) first_j = jv;
      exp_j = jv; exp_k = kv; exp_busy = 1; exp_done = 0; exp_ready = 0;
      abort = (c == abort_at);
      @(posedge clk); #1;
      if (act) begin
        case (op)
          1: m_q = 0;
          2: m_q = MASK;
          3: m_q = data & MASK;
          4: m_q = m_q ^ (data & MASK);
          5: begin
            if (m_q == MASK) m_wrapped = 1;
            m_q = (m_q + 1) & MASK;
          end
          6: m_q = jv;
          default: ;
        endcase
      end
      abort = 1'b0;
      if (c == abort_at) break;
    end
    exp_j = 0; exp_k = 0; exp_busy = 1; exp_done = 1; exp_ready = 0;
    abort = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    idle_exp();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int op, data, count, ab;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0; cmd_count = '0; abort = 1'b0;
    m_q = 0; m_wrapped = 0; m_err = 0; first_j = 0;
    idle_exp();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_q",     32'(q),         32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_j",     32'(j_out),     32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk_en = 1'b1;

    // LOAD 1010
    do_cmd(3, 'b1010, 0, 0);
    chk("load_q", 32'(q), 32'b1010);
    // LOAD 1110 then COUNT 3 through wrap
    do_cmd(3, 'b1110, 0, 0);
    do_cmd(5, 0, 3, 0);
    chk("count_q", 32'(q), 32'b0001);
    chk("count_wrapped", 32'(wrapped), 32'd1);
    chk("count_first_j", 32'(first_j), 32'b0001);
    // LOAD 0, SHIFT 4 ones, TOGGLE 0101
    do_cmd(3, 0, 0, 0);
    do_cmd(6, 1, 4, 0);
    chk("shift_q", 32'(q), 32'b1111);
    do_cmd(4, 'b0101, 0, 0);
    chk("toggle_q", 32'(q), 32'b1010);
    // COUNT 10 aborted in 4th EXEC cycle
    do_cmd(3, 0, 0, 0);
    do_cmd(5, 0, 10, 4);
    chk("abort_q", 32'(q), 32'b0011);
    // illegal op, CLEAR, COUNT 0
    do_cmd(7, 'b1111, 0, 0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_q", 32'(q), 32'b0011);
    do_cmd(1, 0, 0, 0);
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_q", 32'(q), 32'd0);
    do_cmd(2, 0, 0, 0);
    do_cmd(5, 0, 0, 0);
    chk("count0_q", 32'(q), 32'b1111);

    // Reset during the 2nd step of COUNT 5
    do_cmd(3, 0, 0, 0);
    chk_en = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_count = CW'(5); cmd_data = '0;
    @(posedge clk); #1;
    cmd_op = 3'd2;
    @(posedge clk); #1;
    chk("mid_q_before_rst", 32'(q), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_q",     32'(q),         32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_done",  32'(done),      32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_q",     32'(q),         32'd0);
    chk("mid_rst_hold_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rel_q",     32'(q),         32'd0);
    chk("mid_rel_busy",  32'(busy),      32'd0);
    cmd_valid = 1'b0;
    m_q = 0; m_wrapped = 0; m_err = 0;
    idle_exp();
    chk_en = 1'b1;

    // Randomized commands
    for (int t = 0; t < 300; t++) begin
      op    = $urandom_range(0, 7);
      data  = $urandom_range(0, MASK);
      count = $urandom_range(0, 15);
      ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      do_cmd(op, data, count, ab);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven controller for a bank of WIDTH JK flip-flops.
- Each command is turned into per-bit J/K drive sequences: clear, set, load, masked toggle, synchronous up-count and shift.
- The bank state registers live inside the block. The J/K drive vectors are exported so the exported-circuit harness can cross-check them against discrete JK cells.
- Sits between a host or testbench command source and the flip-flop datapath.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank (2..16).
- CNT_W, 4, width of the step-count field for multi-step commands.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  opcode.
- cmd_data  input  WIDTH  operand (load value, toggle mask, shift-in bit in [0]).
- cmd_count  input  CNT_W  step count for COUNT/SHIFT.
- abort  input  1  stop a running command.
- j_out  output  WIDTH  J drive applied this cycle.
- k_out  output  WIDTH  K drive applied this cycle.
- q  output  WIDTH  bank state.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- wrapped  output  1  sticky: COUNT rolled over all-ones to zero.
- err  output  1  sticky: illegal opcode accepted.

Behaviour:
- Reset (async, rst=1):
  - q=0, state=IDLE, j_out=k_out=0, busy=0, done=0, wrapped=0, err=0.
  - cmd_ready=0 while rst is high; cmd_ready=1 from the first cycle after release.
- Handshake:
  - Accept at an edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE). The accept edge latches op/data/count.
  - The accept edge clears wrapped and err before the new command runs.
- States: IDLE, EXEC, DONE.
  - IDLE -> EXEC on accept.
  - EXEC -> DONE after the final step, or when abort is seen.
  - DONE -> IDLE unconditionally after one cycle.
- Outputs per state:
  - busy=1 in EXEC and DONE.
  - done=1 only in DONE.
  - j_out/k_out are nonzero only in EXEC and are driven combinationally from the latched command and current q.
- JK update rule, per bit, at every EXEC edge:
  - J=0,K=0 hold; J=1,K=0 set; J=0,K=1 clear; J=1,K=1 toggle.
  - q is updated only through this rule (no direct writes).
- Opcodes:
  - 0 NOP: one EXEC cycle, J=K=0.
  - 1 CLEAR: J=0, K=all ones; one step.
  - 2 SET: J=all ones, K=0; one step.
  - 3 LOAD: J=data, K=~data; one step.
  - 4 TOGGLE: J=K=data (mask); one step.
  - 5 COUNT: count steps. Per step, J[i]=K[i]=AND(q[i-1:0]), with J[0]=K[0]=1. Synchronous binary increment, modulo 2^WIDTH. A step taking q from all-ones to 0 sets wrapped.
  - 6 SHIFT: count steps, shift left. J[0]=data[0], K[0]=~data[0]. For i>0: J[i]=q[i-1], K[i]=~q[i-1].
  - 7 illegal: sets err, behaves as NOP (one EXEC cycle, J=K=0).
- Timing:
  - Single-step op: accept at edge E0, q changes at E1, done high between E1 and E2, cmd_ready high after E2.
  - N-step op: q changes at E1..EN, done after EN.
  - Back-to-back throughput is one command per N+2 cycles.
- count=0 for COUNT/SHIFT: one EXEC cycle with J=K=0, q unchanged, then DONE.
- Step counter: remaining-steps register, CNT_W bits; max CNT_W ones steps, no extension.
- Abort:
  - abort=1 in an EXEC cycle forces J=K=0 that cycle, so q is unchanged at that edge.
  - The same edge moves to DONE, so done still pulses once.
  - abort in IDLE or DONE is ignored.
- cmd_valid while busy: ignored, not queued. The host must hold cmd_valid until accepted.
- rst asserted mid-command: immediate return to the reset values above. No done pulse is produced.
- cmd_data/cmd_count changes after accept have no effect.

Test Plan:
- Reset, then LOAD data=4'b1010 -> j_out=1010, k_out=0101 in the EXEC cycle; q=1010 at E1; done pulses exactly once; cmd_ready returns after 3 cycles total.
- LOAD 4'b1110, then COUNT count=3 -> q sequence 1111, 0000, 0001; wrapped=1 after the second step; done after the third step; in the first step j_out=k_out=0001.
- LOAD 0, then SHIFT count=4 data[0]=1 -> q = 0001, 0011, 0111, 1111; then TOGGLE data=4'b0101 -> q=1010.
- COUNT count=10 from q=0 with abort asserted in the 4th EXEC cycle -> q stops at 0011; done pulses the next cycle; busy drops afterwards.
- op=7 -> err=1, q unchanged, done pulses. A following CLEAR accept clears err and gives q=0000. COUNT count=0 -> q unchanged and done still pulses.
- Assert rst during the 2nd step of COUNT count=5 -> q=0, busy=0, done=0, cmd_ready=0 while rst is high. cmd_ready=1 the cycle after release; cmd_valid held during reset is not accepted.
